// File: rtl/fetch_pkg.sv
// Shared widths, queue entry type and clog2 helper for the fetch queue unit.
// Every fetch-queue file sizes itself from these constants.
package fetch_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    localparam int XLEN     = 16;
    localparam int AW       = 16;
    localparam int FETCH_W  = 2;
    localparam int ISSUE_W  = 2;
    localparam int QDEPTH   = 8;

    localparam int PTR_W    = clog2(QDEPTH);
    localparam int CNT_W    = clog2(QDEPTH + 1);
    localparam int IC_W     = clog2(ISSUE_W + 1);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [AW-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory and decode-side signals of the fetch queue unit.
// master = fetch unit, slave = memory/decode environment.
interface fetch_queue_unit_if;
    import fetch_pkg::*;

    logic                      imem_req;
    logic [AW-1:0]             imem_addr;
    logic                      imem_rvalid;
    logic [FETCH_W*XLEN-1:0]   imem_rdata;
    logic                      redirect_valid;
    logic [AW-1:0]             redirect_pc;
    logic [ISSUE_W-1:0]        out_valid;
    logic [ISSUE_W*XLEN-1:0]   out_instr;
    logic [ISSUE_W*AW-1:0]     out_pc;
    logic [IC_W-1:0]           issue_count;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, issue_count
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, issue_count
    );

endinterface

// File: rtl/fetch_ring_buffer.sv
// Circular queue: FETCH_W-wide enqueue at tail, 0..ISSUE_W dequeue at head, flush.
// Read lanes are masked to zero beyond the valid count.
module fetch_ring_buffer
    import fetch_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       enq_i,
    input  fetch_entry_t [FETCH_W-1:0] enq_data_i,
    input  logic [IC_W-1:0]            deq_cnt_i,
    output logic [CNT_W-1:0]           count_o,
    output logic [ISSUE_W-1:0]         rd_valid_o,
    output fetch_entry_t [ISSUE_W-1:0] rd_data_o
);

    fetch_entry_t     mem_q [QDEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, nvalid, deq_eff;

    // Over-large dequeue requests are clamped to what is actually presented.
    always_comb begin
        nvalid  = (count_q > CNT_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : count_q;
        deq_eff = (CNT_W'(deq_cnt_i) > nvalid) ? nvalid : CNT_W'(deq_cnt_i);
        head_d  = head_q + PTR_W'(deq_eff);
        tail_d  = enq_i ? tail_q + PTR_W'(FETCH_W) : tail_q;
        count_d = count_q - deq_eff + (enq_i ? CNT_W'(FETCH_W) : '0);
        if (flush_i) begin
            head_d  = tail_q;
            tail_d  = tail_q;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_i && !flush_i)
            for (int k = 0; k < FETCH_W; k++)
                mem_q[tail_q + PTR_W'(k)] <= enq_data_i[k];
    end

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            rd_valid_o[i] = count_q > CNT_W'(i);
            rd_data_o[i]  = (count_q > CNT_W'(i)) ? mem_q[head_q + PTR_W'(i)] : '0;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Multi-wide fetch stage: PC, request throttling and in-flight tracking around the ring buffer.
// Define FETCH_QUEUE_PERF_EN to add saturating fetched/flushed counters.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    fetch_queue_unit_if.master  bus
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]         perf_fetched_o,
    output logic [31:0]         perf_flushed_o
`endif
);

    logic [AW-1:0]              pc_q, pc_d, req_addr_q;
    logic                       inflight_q, inflight_d;
    logic                       req, enq;
    logic [CNT_W-1:0]           count, nvalid;
    logic [CNT_W:0]             used;
    fetch_entry_t [FETCH_W-1:0] enq_data;
    logic [ISSUE_W-1:0]         rd_valid;
    fetch_entry_t [ISSUE_W-1:0] rd_data;

    // Room accounts for a response already on its way so the queue can never overflow.
    assign used = {1'b0, count} + (inflight_q ? (CNT_W+1)'(FETCH_W) : '0);
    assign req  = !reset && !bus.redirect_valid && (used <= (CNT_W+1)'(QDEPTH - FETCH_W));
    assign enq  = bus.imem_rvalid && inflight_q && !bus.redirect_valid;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_pc;
            inflight_d = 1'b0;
        end else if (req) begin
            pc_d       = pc_q + AW'(FETCH_W);
            inflight_d = 1'b1;
        end else if (bus.imem_rvalid) begin
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_addr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            if (req) req_addr_q <= pc_q;
        end
    end

    for (genvar k = 0; k < FETCH_W; k++) begin : g_enq
        assign enq_data[k].instr = bus.imem_rdata[k*XLEN +: XLEN];
        assign enq_data[k].pc    = req_addr_q + AW'(k);
    end

    fetch_ring_buffer u_ring (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (bus.redirect_valid),
        .enq_i      (enq),
        .enq_data_i (enq_data),
        .deq_cnt_i  (bus.issue_count),
        .count_o    (count),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = rd_valid;

    for (genvar i = 0; i < ISSUE_W; i++) begin : g_out
        assign bus.out_instr[i*XLEN +: XLEN] = rd_data[i].instr;
        assign bus.out_pc[i*AW +: AW]        = rd_data[i].pc;
    end

    assign nvalid = (count > CNT_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : count;

    a_issue_le_valid: assert property (@(posedge clk) disable iff (reset)
        !bus.redirect_valid |-> (CNT_W'(bus.issue_count) <= nvalid));

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] fetched_q, flushed_q;
    logic [32:0] fetched_sum, flushed_sum;

    assign fetched_sum = {1'b0, fetched_q} + 33'(FETCH_W);
    assign flushed_sum = {1'b0, flushed_q} + 33'(count)
                       + ((bus.imem_rvalid && inflight_q) ? 33'(FETCH_W) : 33'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (enq)
                fetched_q <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            if (bus.redirect_valid)
                flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_flushed_o = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: memory model mem[a]=16'h1000+a,
// expected in-order stream restarted on every reset/redirect.
module tb_fetch_queue_unit;

    logic clk = 1'b0;
    logic reset;
    logic rv_q = 1'b0;
    logic [15:0] raddr_q = '0;
    logic [1:0] last_vld;
    logic [31:0] sb[$];
    int n_chk = 0;
    int n_fail = 0;

    fetch_queue_unit_if bus_if ();

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    fetch_queue_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_fetched_o (perf_fetched),
        .perf_flushed_o (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    always @(posedge clk) begin
        rv_q    <= bus_if.imem_req;
        raddr_q <= bus_if.imem_addr;
    end
    assign bus_if.imem_rvalid = rv_q;
    assign bus_if.imem_rdata  = {mem(raddr_q + 16'd1), mem(raddr_q)};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sb_restart(input logic [15:0] p);
        sb.delete();
        for (int k = 0; k < 160; k++)
            sb.push_back({mem(p + 16'(k)), p + 16'(k)});
    endtask

    // One cycle: observe at negedge, score consumed lanes, then drive next inputs.
    task automatic step(input int want, input bit redir = 1'b0, input logic [15:0] rpc = '0);
        int nv, ic;
        logic [31:0] e;
        @(negedge clk);
        last_vld = bus_if.out_valid;
        chk("contig", {63'd0, last_vld == 2'b10}, 64'd0);
        nv = 0;
        for (int i = 0; i < 2; i++) begin
            if (last_vld[i]) nv = i + 1;
            else chk("zero_lane", {32'd0, bus_if.out_instr[i*16 +: 16], bus_if.out_pc[i*16 +: 16]}, 64'd0);
        end
        if (redir) begin
            bus_if.redirect_valid = 1'b1;
            bus_if.redirect_pc    = rpc;
            bus_if.issue_count    = '0;
            sb_restart(rpc);
        end else begin
            bus_if.redirect_valid = 1'b0;
            ic = (want < nv) ? want : nv;
            for (int i = 0; i < ic; i++) begin
                chk("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("instr", {48'd0, bus_if.out_instr[i*16 +: 16]}, {48'd0, e[31:16]});
                    chk("pc", {48'd0, bus_if.out_pc[i*16 +: 16]}, {48'd0, e[15:0]});
                end
            end
            bus_if.issue_count = 2'(ic);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = '0;
        bus_if.issue_count    = '0;
        repeat (3) @(negedge clk);
        chk("rst_req",   {63'd0, bus_if.imem_req}, 64'd0);
        chk("rst_vld",   {62'd0, bus_if.out_valid}, 64'd0);
        chk("rst_instr", {32'd0, bus_if.out_instr}, 64'd0);
        chk("rst_pc",    {32'd0, bus_if.out_pc}, 64'd0);

        // Latency from reset release.
        reset = 1'b0;
        sb_restart(16'h0000);
        #1;
        chk("req_c1",  {63'd0, bus_if.imem_req}, 64'd1);
        chk("addr_c1", {48'd0, bus_if.imem_addr}, 64'd0);
        step(2); chk("lat_c2", {62'd0, last_vld}, 64'd0);
        step(2); chk("lat_c3", {62'd0, last_vld}, 64'd3);
        repeat (20) step(2);

        // Stall until full.
        repeat (10) step(0);
        #1;
        chk("full_vld",   {62'd0, last_vld}, 64'd3);
        chk("full_noreq", {63'd0, bus_if.imem_req}, 64'd0);
        repeat (20) step(2);

        // Single issue.
        repeat (30) step(1);
        repeat (4) step(2);

        // Redirect while a response is in flight.
        for (int t = 0; t < 10; t++) begin
            step(2);
            #1;
            if (bus_if.imem_req) break;
        end
        chk("inflight_pre", {63'd0, bus_if.imem_req}, 64'd1);
        step(0, 1'b1, 16'h0040);
        step(2); chk("rd_gap1", {62'd0, last_vld}, 64'd0);
        #1;
        chk("rd_req",  {63'd0, bus_if.imem_req}, 64'd1);
        chk("rd_addr", {48'd0, bus_if.imem_addr}, 64'h0040);
        step(2); chk("rd_gap2", {62'd0, last_vld}, 64'd0);
        step(2); chk("rd_vis",  {62'd0, last_vld}, 64'd3);
        repeat (10) step(2);

        // PC wrap.
        step(0, 1'b1, 16'hFFFF);
        step(2); #1; chk("wrap_a0", {48'd0, bus_if.imem_addr}, 64'hFFFF);
        step(2); #1; chk("wrap_a1", {48'd0, bus_if.imem_addr}, 64'h0001);
        repeat (12) step(2);

        // Reset with 5 entries queued and a response pending.
        step(0, 1'b1, 16'h0100);
        step(0);
        step(0);
        step(1); chk("mid_vld", {62'd0, last_vld}, 64'd3);
        step(0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_req",   {63'd0, bus_if.imem_req}, 64'd0);
        chk("mid_rst_vld",   {62'd0, bus_if.out_valid}, 64'd0);
        chk("mid_rst_instr", {32'd0, bus_if.out_instr}, 64'd0);
        chk("mid_rst_pc",    {32'd0, bus_if.out_pc}, 64'd0);
        #1;
        reset = 1'b0;
        bus_if.issue_count = '0;
        sb_restart(16'h0000);
        #1;
        chk("mid_addr", {48'd0, bus_if.imem_addr}, 64'd0);
        step(2); chk("mid_lat2", {62'd0, last_vld}, 64'd0);
        step(2); chk("mid_lat3", {62'd0, last_vld}, 64'd3);
        repeat (10) step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised multi-wide fetch stage for the superscalar core.
- Each cycle it requests FETCH_W consecutive instructions from the instruction memory.
- Returned instructions are buffered in a QDEPTH-entry circular queue.
- Up to ISSUE_W instructions per cycle are presented to decode. The consumer reports how many it took (0..ISSUE_W), which replaces the single/dual-issue flag. A branch redirect flushes the queue and any in-flight response.

Parameters:
- XLEN, 16, instruction width in bits.
- AW, 16, PC/address width; word-addressed, one instruction per address.
- FETCH_W, 2, instructions returned per memory request.
- ISSUE_W, 2, instructions presented to decode per cycle.
- QDEPTH, 8, queue entries; power of two, QDEPTH >= 2*FETCH_W.
- RESET_PC, 0, PC loaded at reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  AW  address of first instruction in the request.
- imem_rvalid  in  1  response valid; asserted exactly 1 cycle after the accepted request.
- imem_rdata  in  FETCH_W*XLEN  lane k (bits k*XLEN+:XLEN) = mem[addr+k].
- redirect_valid  in  1  taken branch / flush.
- redirect_pc  in  AW  new fetch PC.
- out_valid  out  ISSUE_W  lane i valid iff queue count > i; always contiguous from lane 0.
- out_instr  out  ISSUE_W*XLEN  head..head+ISSUE_W-1 entries; zero where lane invalid.
- out_pc  out  ISSUE_W*AW  PC of each presented instruction; zero where lane invalid.
- issue_count  in  clog2(ISSUE_W+1)  number of lanes consumed this cycle; 0 = stall.

Behaviour:
- Reset (async):
  - pc=RESET_PC; queue empty (head=tail=count=0); inflight=0.
  - imem_req=0, out_valid=0, out_instr=0, out_pc=0.
  - First request is issued in the first cycle after reset deasserts.
- Request rule:
  - imem_req = !redirect_valid && (QDEPTH - count - (inflight ? FETCH_W : 0)) >= FETCH_W, using registered count.
  - When a request is issued: imem_addr = pc; pc <= pc + FETCH_W (mod 2^AW, wraps); inflight <= 1.
  - No alignment constraint on pc.
- Response: on imem_rvalid with inflight=1, all FETCH_W lanes are written at the tail with PCs addr..addr+FETCH_W-1; tail += FETCH_W.
- Dequeue: head += issue_count, count -= issue_count.
- Simultaneous enqueue and dequeue in the same cycle is legal: count <= count + FETCH_W - issue_count.
- issue_count > number of valid lanes is illegal; it fires an assertion, and the design then clamps issue_count to the valid lane count.
- No bypass: a response at cycle t is first visible on out_* at t+1.
- Latency: reset release -> req cycle 1 -> rvalid cycle 2 -> out_valid cycle 3.
- Redirect at cycle t:
  - Queue cleared (count=0, head=tail), so out_valid=0 at t+1.
  - pc <= redirect_pc; no request at t.
  - Response arriving at t or t+1 from a pre-redirect request is dropped (inflight cleared at t).
  - Request for redirect_pc at t+1; its response at t+2; out_valid at t+3.
  - issue_count during the redirect cycle is ignored.
- Redirect has priority over response, dequeue and request.
- Redirect held high for several cycles: queue stays empty, pc keeps loading redirect_pc.
- Full: no request when insufficient room, so the queue never overflows. Empty: out_valid=0.
- Head and tail pointers wrap modulo QDEPTH.
- Reset mid-operation: all state cleared immediately; a pending response in the next cycle is ignored (inflight=0).

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- Defined: adds outputs perf_fetched (32 bits) and perf_flushed (32 bits).
  - perf_fetched increments by FETCH_W per accepted response.
  - perf_flushed increments by the count discarded on redirect, plus FETCH_W if a response is dropped.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - Localparams for the count and pointer widths.
  - Typedef fetch_entry_t {instr[XLEN], pc[AW]}.
  - The helper clog2.
- One sub-module: fetch_ring_buffer. It is a multi-write/multi-read circular queue with head, tail and count, a flush input, an enqueue of FETCH_W entries, and a variable dequeue of 0..ISSUE_W entries. fetch_queue_unit contains the PC, request and in-flight control.

Test Plan:
- Reset then free-run with mem[i]=16'h1000+i and issue_count=2: out_valid=2'b11 from cycle 3; lanes carry 1000/1001, then 1002/1003, and so on; out_pc=0/1, 2/3.
- issue_count=0 held for 10 cycles: count reaches 8 and stops; imem_req=0; no overwrite. Then issue_count=2: instructions resume in order with no gap or duplicate.
- issue_count=1 continuously: only lane 0 is consumed per cycle; the queue fills and requests throttle; the sequence stays strictly 1000, 1001, 1002, and so on.
- redirect_valid with redirect_pc=16'h0040 while a response is in flight: that response is dropped; out_valid=0 for 2 cycles; next out_instr=mem[40]/mem[41], out_pc=0040/0041.
- pc wrap: redirect_pc=16'hFFFF: request addresses FFFF, then 0001; lanes have PCs FFFF/0000, then 0001/0002.
- Assert reset while the queue holds 5 entries and a response is pending: all outputs are 0 immediately; the post-reset stream restarts at RESET_PC; the pending response is ignored.
